// File: rtl/spi_slave_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_pkg
// Shared constants and types for the SPI slave endpoint.
//   SPI_DATA_W     default word width
//   SPI_IDLE_FILL  word shifted out when the host has not loaded anything
//   MODE0..MODE3   SPI mode encodings as {CPOL, CPHA}
//   spi_state_t    FSM state type
// -----------------------------------------------------------------------------
package spi_slave_pkg;

  localparam int         SPI_DATA_W    = 8;
  localparam logic       SPI_IDLE_BIT  = 1'b1;
  localparam logic [7:0] SPI_IDLE_FILL = {8{SPI_IDLE_BIT}};

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEL  = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
// The four SPI pins between a master and the slave endpoint.
//   ss_n       slave select, active low   (master -> slave)
//   slave_clk  SCLK                       (master -> slave)
//   mosi       serial data                (master -> slave)
//   miso       serial data                (slave  -> master)
// -----------------------------------------------------------------------------
interface spi_slave_if;

  logic ss_n;
  logic slave_clk;
  logic mosi;
  logic miso;

  modport master (
    output ss_n,
    output slave_clk,
    output mosi,
    input  miso
  );

  modport slave (
    input  ss_n,
    input  slave_clk,
    input  mosi,
    output miso
  );

endinterface

// File: rtl/spi_slave_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Synchroniser for the asynchronous SPI pins into the clk domain, with
// rise/fall detection on SCLK. SCLK and the auxiliary pins (ss_n, mosi) go
// through the same flop chain, so a data pin and the clock edge that
// qualifies it arrive in the same clk cycle.
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   sclk_in      raw SCLK pin
//   aux_in       raw auxiliary pins (synchronised only)
//   aux_sync     synchronised auxiliary pins
//   sclk_rise    1-clk pulse: synchronised SCLK went 0 -> 1
//   sclk_fall    1-clk pulse: synchronised SCLK went 1 -> 0
// -----------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int               AUX_W   = 2,
  parameter int               STAGES  = 2,
  parameter logic [AUX_W-1:0] AUX_RST = {AUX_W{1'b0}},
  parameter logic             CLK_RST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk_in,
  input  logic [AUX_W-1:0] aux_in,
  output logic [AUX_W-1:0] aux_sync,
  output logic             sclk_rise,
  output logic             sclk_fall
);

  // Depth below two would not be a real synchroniser.
  localparam int ST = (STAGES < 2) ? 2 : STAGES;
  localparam int W  = AUX_W + 1;

  // sync_r[0] is the first flop, sync_r[ST-1] the settled output.
  logic [ST-1:0][W-1:0] sync_r;
  logic                 sclk_prev_r;

  // Shift the raw pins through the chain and remember the last SCLK sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r      <= {ST{{AUX_RST, CLK_RST}}};
      sclk_prev_r <= CLK_RST;
    end else begin
      sync_r      <= {sync_r[ST-2:0], {aux_in, sclk_in}};
      sclk_prev_r <= sync_r[ST-1][0];
    end
  end

  assign aux_sync  = sync_r[ST-1][W-1:1];
  assign sclk_rise = sync_r[ST-1][0] & ~sclk_prev_r;
  assign sclk_fall = ~sync_r[ST-1][0] & sclk_prev_r;

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI slave endpoint, full duplex, MSB first, all four CPOL/CPHA modes.
// Every SPI pin is oversampled in the clk domain; nothing runs on SCLK.
// Ports:
//   clk, reset          system clock (>= 2*(SYNC_STAGES+1) x SCLK),
//                       asynchronous active-high reset
//   w_CPOL, w_CPHA      SPI mode; static while busy=1
//   spi                 SPI pins (spi_slave_if.slave)
//   data_in, load       host TX word and write strobe (taken when tx_ready=1)
//   tx_ready            TX holding buffer empty
//   data_out            last complete RX word
//   data_out_received   1-clk pulse when data_out updates
//   busy                transfer window open (synchronised ss_n low)
// Optional feature, macro SPI_SLAVE_OVERRUN_EN:
//   data_read           host acknowledge of data_out
//   rx_overrun          sticky: a word completed before the previous was read
// -----------------------------------------------------------------------------
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_CPOL,
  input  logic              w_CPHA,
  spi_slave_if.slave        spi,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_received,
  output logic              busy
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  input  logic              data_read,
  output logic              rx_overrun
`endif
);

  localparam int                CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] IDLE_FILL = {DATA_W{SPI_IDLE_BIT}};

  spi_state_t        state_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] rx_shift_r;
  logic [DATA_W-1:0] tx_shift_r;
  logic [DATA_W-1:0] tx_buf_r;
  logic              miso_r;

  logic              ss_sync_s;
  logic              mosi_sync_s;
  logic              sclk_rise_s;
  logic              sclk_fall_s;
  logic              lead_s;
  logic              trail_s;
  logic              active_s;
  logic              sample_s;
  logic              shift_s;
  logic              enter_sel_s;
  logic              load_evt_s;
  logic              complete_s;
  logic              tx_consume_s;
  logic              tx_accept_s;
  logic [DATA_W-1:0] rx_word_s;
  logic [DATA_W-1:0] tx_word_s;
  logic [DATA_W-1:0] tx_shift_nxt_s;

  // ss_n resets high so the endpoint comes out of reset deselected.
  spi_sync_edge #(
    .AUX_W   (2),
    .STAGES  (SYNC_STAGES),
    .AUX_RST (2'b10),
    .CLK_RST (1'b0)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .sclk_in   (spi.slave_clk),
    .aux_in    ({spi.ss_n, spi.mosi}),
    .aux_sync  ({ss_sync_s, mosi_sync_s}),
    .sclk_rise (sclk_rise_s),
    .sclk_fall (sclk_fall_s)
  );

  // Edge classification, load events and next TX shifter contents.
  always_comb begin
    lead_s         = 1'b0;
    trail_s        = 1'b0;
    sample_s       = 1'b0;
    shift_s        = 1'b0;
    tx_word_s      = IDLE_FILL;
    tx_shift_nxt_s = tx_shift_r;

    // Leading edge moves SCLK away from its idle level.
    if (w_CPOL) begin
      lead_s  = sclk_fall_s;
      trail_s = sclk_rise_s;
    end else begin
      lead_s  = sclk_rise_s;
      trail_s = sclk_fall_s;
    end

    active_s = (state_r == ST_SEL) && !ss_sync_s;

    if (w_CPHA) begin
      sample_s = active_s && trail_s;
      shift_s  = active_s && lead_s;
    end else begin
      sample_s = active_s && lead_s;
      shift_s  = active_s && trail_s;
    end

    enter_sel_s = (state_r == ST_IDLE) && !ss_sync_s;

    // A shift edge with bit_cnt at zero is the first shift of a word for
    // CPHA=1 and the shift right after a word's last sample for CPHA=0.
    load_evt_s = (enter_sel_s && !w_CPHA) || (shift_s && (bit_cnt_r == CNT_ZERO));
    complete_s = sample_s && (bit_cnt_r == CNT_LAST);
    rx_word_s  = {rx_shift_r[DATA_W-2:0], mosi_sync_s};

    if (tx_ready) begin
      tx_word_s = IDLE_FILL;
    end else begin
      tx_word_s = tx_buf_r;
    end

    if (load_evt_s) begin
      tx_shift_nxt_s = tx_word_s;
    end else if (shift_s) begin
      tx_shift_nxt_s = {tx_shift_r[DATA_W-2:0], 1'b0};
    end else begin
      tx_shift_nxt_s = tx_shift_r;
    end

    // The buffer is consumed before a same-cycle host write is accepted.
    tx_consume_s = load_evt_s && !tx_ready;
    tx_accept_s  = load && (tx_ready || tx_consume_s);
  end

  // TX holding buffer: host writes in, load events drain it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_buf_r <= {DATA_W{1'b0}};
      tx_ready <= 1'b1;
    end else if (tx_accept_s) begin
      tx_buf_r <= data_in;
      tx_ready <= 1'b0;
    end else if (tx_consume_s) begin
      tx_ready <= 1'b1;
    end
  end

  // Transfer FSM with the RX/TX shifters and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r           <= ST_IDLE;
      busy              <= 1'b0;
      miso_r            <= 1'b1;
      bit_cnt_r         <= CNT_ZERO;
      rx_shift_r        <= {DATA_W{1'b0}};
      tx_shift_r        <= {DATA_W{1'b0}};
      data_out          <= {DATA_W{1'b0}};
      data_out_received <= 1'b0;
    end else begin
      data_out_received <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          bit_cnt_r <= CNT_ZERO;
          if (enter_sel_s) begin
            state_r    <= ST_SEL;
            busy       <= 1'b1;
            tx_shift_r <= tx_shift_nxt_s;
            miso_r     <= tx_shift_nxt_s[DATA_W-1];
          end else begin
            busy   <= 1'b0;
            miso_r <= 1'b1;
          end
        end
        ST_SEL: begin
          if (ss_sync_s) begin
            // Deselect: a partial word is dropped, data_out is kept.
            state_r   <= ST_IDLE;
            busy      <= 1'b0;
            miso_r    <= 1'b1;
            bit_cnt_r <= CNT_ZERO;
          end else begin
            tx_shift_r <= tx_shift_nxt_s;
            miso_r     <= tx_shift_nxt_s[DATA_W-1];
            if (sample_s) begin
              rx_shift_r <= rx_word_s;
              if (complete_s) begin
                data_out          <= rx_word_s;
                data_out_received <= 1'b1;
                bit_cnt_r         <= CNT_ZERO;
              end else begin
                bit_cnt_r <= bit_cnt_r + CNT_ONE;
              end
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          busy      <= 1'b0;
          miso_r    <= 1'b1;
          bit_cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

  assign spi.miso = miso_r;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_full_r;

  // Unread-word tracking: a completion on top of an unread word is an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_full_r  <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (complete_s) begin
      rx_full_r <= 1'b1;
      if (data_read) begin
        rx_overrun <= 1'b0;
      end else if (rx_full_r) begin
        rx_overrun <= 1'b1;
      end
    end else if (data_read) begin
      rx_full_r  <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end
`endif

endmodule
